toggle_event_receiver: RTL
==========================

// Module: toggle_event_receiver
// PURPOSE
//  Receive end of the toggle-signalling link driven by the team's T flip-flop
//  stages. Each level change on tog_in (async, another clock domain) is one event.
//  The block synchronises tog_in, detects each toggle and emits a 1-cycle pulse.
//  It counts undrained events and hands them to a consumer via valid/ready.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser flops on tog_in; legal range >= 2
//  CNT_W        4  width of pending-event counter; holds 0 .. 2**CNT_W-1
// PORTS
//  clk        in   1      clock, all logic on posedge
//  rst        in   1      synchronous reset, active-high
//  tog_in     in   1      async toggle line from sender; one level change = one event
//  evt_pulse  out  1      1-cycle pulse per detected toggle
//  evt_valid  out  1      high while pend_cnt != 0
//  evt_ready  in   1      consumer accepts one event when evt_valid && evt_ready
//  pend_cnt   out  CNT_W  events detected but not yet accepted
//  overflow   out  1      sticky: event lost because counter was full
//  clr_ovf    in   1      clears overflow (synchronous)
//  ack_tog    out  1      return toggle to sender (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values, applied at the clk edge while rst=1:
//    - all sync flops = 0, prev = 0, evt_pulse = 0, pend_cnt = 0
//    - overflow = 0, ack_tog = 0; evt_valid = 0 follows from pend_cnt = 0
//  - Reset mid-operation discards all pending events and any toggle in flight.
//  - Sync chain: s[0] <= tog_in; s[i] <= s[i-1]; ts = s[SYNC_STAGES-1].
//  - Toggle detect: det = ts ^ prev; prev <= ts every cycle.
//  - prev resets to 0. If tog_in is 1 after reset, that counts as one event (by design).
//  - evt_pulse <= det, so it is high one cycle after det.
//    Latency from tog_in change to evt_pulse high = SYNC_STAGES+1 clk edges.
//  - Sender must hold each level >= SYNC_STAGES+1 clk cycles. A faster double toggle
//    cancels and is lost; no detection of this case is required.
//  - acc = evt_valid && evt_ready. evt_valid is combinational (pend_cnt != 0).
//    evt_ready may be high while evt_valid = 0; no effect.
//  - pend_cnt update, by (det, acc):
//    - 1,0: +1, if not full
//    - 0,1: -1
//    - 1,1: unchanged, even at full or at 1
//    - 0,0: unchanged
//  - Full = 2**CNT_W-1. det && !acc at full: pend_cnt holds at full, overflow <= 1,
//    the event is dropped. evt_pulse still fires.
//  - overflow stays set until clr_ovf. clr_ovf and a new overflow in the same cycle:
//    set wins, overflow stays 1.
//  - Underflow is impossible: acc requires pend_cnt != 0.
//  - No combinational path from tog_in to any output. evt_valid depends only on regs.
// CONFIGURATION
//  - Macro TOGGLE_ACK_EN defined: ack_tog flips on every accepted event (acc=1).
//    Reset value 0. The sender compares ack_tog (synchronised on its side) with its
//    own toggle to get flow control.
//  - Macro not defined: ack_tog tied to constant 0, no ack flop built.
//    All other behaviour is identical.
// TESTING
//  1. rst=1 for 3 cycles, tog_in=0 -> all outputs 0; after rst drops, no evt_pulse.
//  2. SYNC_STAGES=2; tog_in 0->1 just after edge k -> evt_pulse high for exactly one
//     cycle after edge k+3; pend_cnt=1; evt_valid=1.
//  3. 5 toggles spaced 4 cycles, evt_ready=0 -> 5 pulses; pend_cnt=5; then
//     evt_ready=1 -> evt_valid drops after 5 accepts; pend_cnt=0.
//     With TOGGLE_ACK_EN, ack_tog ends at 1 (5 flips).
//  4. CNT_W=4, evt_ready=0, 16 toggles -> pend_cnt=15, overflow=1;
//     clr_ovf pulse -> overflow=0, pend_cnt stays 15.
//  5. pend_cnt=15, evt_ready=1 in the same cycle as det -> pend_cnt stays 15,
//     overflow stays 0.
//  6. pend_cnt=3, rst pulsed for 1 cycle -> pend_cnt=0, evt_valid=0, ack_tog=0;
//     next toggle counts from 1.

Source files
------------

// File: rtl/toggle_event_receiver.sv
// Toggle-link receiver: sync tog_in, 1-cycle evt_pulse SYNC_STAGES+1 edges after each level change, events queued in pend_cnt.
// Backpressure: evt_ready low holds events (pend_cnt saturates, sticky overflow marks drops); TOGGLE_ACK_EN adds the ack_tog return toggle.
module toggle_event_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tog_in,
   output logic             evt_pulse,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [CNT_W-1:0] pend_cnt,
   output logic             overflow,
   input  logic             clr_ovf,
   output logic             ack_tog
);

   localparam logic [CNT_W-1:0] CNT_FULL = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   pulse_q, pulse_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;

   logic ts;
   logic det;
   logic acc;
   logic cnt_full;
   logic drop;

   assign ts       = sync_q[SYNC_STAGES-1];
   assign det      = ts ^ prev_q;
   assign cnt_full = (cnt_q == CNT_FULL);
   // valid comes only from the counter register, never from the sync chain
   assign evt_valid = (cnt_q != '0);
   assign acc       = evt_valid & evt_ready;
   assign drop      = det & ~acc & cnt_full;

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], tog_in};
      prev_d  = ts;
      pulse_d = det;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;

      // a simultaneous detect and accept cancel out, so full+accept never drops
      unique case ({det, acc})
         2'b10:   if (!cnt_full) cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase

      if (clr_ovf) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign evt_pulse = pulse_q;
   assign pend_cnt  = cnt_q;
   assign overflow  = ovf_q;

`ifdef TOGGLE_ACK_EN
   logic ack_q, ack_d;

   assign ack_d = ack_q ^ acc;

   always_ff @(posedge clk) begin
      if (rst) ack_q <= 1'b0;
      else     ack_q <= ack_d;
   end

   assign ack_tog = ack_q;
`else
   assign ack_tog = 1'b0;
`endif

endmodule
